// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point radix-4 FFT datapath.
// Holds frame geometry, float32 bit-pattern constants, the inter-stage
// twiddle exponent rule and the scheduler FSM state encoding.
package fft_pkg;

    // Frame geometry: 16 points, two radix-4 stages.
    localparam int FFT_N  = 16;
    localparam int LOG4_N = 2;

    // Raw float32 bit patterns used by neighbouring blocks and benches.
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_TWO  = 32'h4000_0000;

    // Complex sample as two raw float32 words.
    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cplx_t;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Twiddle exponent between the two radix-4 stages: e = q*r, 0..9.
    function automatic logic [3:0] tw_exp(input logic [1:0] q, input logic [1:0] r);
        return {2'b00, q} * {2'b00, r};
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Purpose: synchronous first-word-fall-through FIFO with occupancy count.
// Latency: a pushed word is visible on o_pop_dat the cycle after the push edge.
// Backpressure: push is dropped only when full with no pop; pop ignored when empty.
module sync_fifo_fwft #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop_rdy,
    output logic             o_pop_vld,
    output logic [WIDTH-1:0] o_pop_dat,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_push;
    logic w_pop;

    assign w_pop  = i_pop_rdy && (r_count != '0);
    // A push into a full FIFO is still safe when a pop frees a slot the same cycle.
    assign w_push = i_push_vld && ((r_count != DEPTH_C) || w_pop);

    assign o_pop_vld = (r_count != '0);
    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array: written on push, no reset needed for data.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/twiddle_mul_sched.sv
// Purpose: feeds one 16-sample frame through a shared complex multiplier with W16^(q*r) twiddles.
// Latency: accept cycle t -> operands at t+1 -> FIFO write end of t+1+MUL_LAT -> out_valid at t+2+MUL_LAT.
// Backpressure: in_ready is a credit check (in-flight + FIFO occupancy < FIFO_DEPTH), so no product is lost.
module twiddle_mul_sched
    import fft_pkg::*;
#(
    parameter int MUL_LAT    = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_real,
    input  logic [31:0] in_im,
    output logic [3:0]  tw_addr,
    input  logic [31:0] tw_real,
    input  logic [31:0] tw_im,
    output logic [31:0] mul_a_real,
    output logic [31:0] mul_a_im,
    output logic [31:0] mul_b_real,
    output logic [31:0] mul_b_im,
    input  logic [31:0] mul_c_real,
    input  logic [31:0] mul_c_im,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_real,
    output logic [31:0] out_im,
    output logic        out_last
);

    // FIFO_DEPTH must be a power of two and at least MUL_LAT+2.
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam int          CW       = AW + 1;
    localparam logic [CW:0] DEPTH_C  = FIFO_DEPTH[CW:0];
    localparam logic [3:0]  LAST_IDX = 4'(FFT_N - 1);

    state_t        r_state;
    logic [3:0]    r_idx;
    logic          r_busy;
    logic          r_done;
    logic [CW-1:0] r_inflight;
    logic [MUL_LAT:0] r_vpipe;
    logic [31:0]   r_mul_a_real;
    logic [31:0]   r_mul_a_im;
    logic [3:0]    r_out_cnt;

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_in_ready;
    logic          w_fifo_vld;
    logic [63:0]   w_fifo_dat;
    logic [63:0]   w_push_dat;
    logic [CW-1:0] w_fifo_count;
    logic [CW:0]   w_credit_used;
    cplx_t         w_prod;

    // Credits: every accepted sample holds one slot until it leaves the FIFO.
    assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_fifo_count};
    assign w_in_ready    = (r_state == ST_RUN) && (w_credit_used < DEPTH_C);
    assign w_accept      = in_valid && w_in_ready;

    // The product word appears at the multiplier output exactly when the valid pipe says so.
    assign w_push  = r_vpipe[MUL_LAT];
    assign w_pop   = w_fifo_vld && out_ready;
    assign w_prod  = '{re: mul_c_real, im: mul_c_im};
    assign w_push_dat = w_prod;

    assign in_ready   = w_in_ready;
    assign busy       = r_busy;
    assign done       = r_done;
    assign tw_addr    = (r_state == ST_RUN) ? tw_exp(r_idx[3:2], r_idx[1:0]) : 4'd0;
    assign mul_a_real = r_mul_a_real;
    assign mul_a_im   = r_mul_a_im;
    // The ROM has one cycle of read latency, lining its data up with the registered sample.
    assign mul_b_real = tw_real;
    assign mul_b_im   = tw_im;
    assign out_valid  = w_fifo_vld;
    assign out_real   = w_fifo_dat[63:32];
    assign out_im     = w_fifo_dat[31:0];
    assign out_last   = w_fifo_vld && (r_out_cnt == LAST_IDX);

    // Frame sequencer with registered busy/done decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_RUN;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == LAST_IDX) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((r_inflight == '0) && !w_fifo_vld) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Operand A register: captures the sample on the accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mul_a_real <= '0;
            r_mul_a_im   <= '0;
        end else if (w_accept) begin
            r_mul_a_real <= in_real;
            r_mul_a_im   <= in_im;
        end
    end

    // Valid pipe: one bit per multiplier stage plus the operand register stage.
    generate
        if (MUL_LAT == 0) begin : g_vpipe_comb
            always_ff @(posedge clk) begin
                if (!rst_n) r_vpipe <= '0;
                else        r_vpipe <= w_accept;
            end
        end else begin : g_vpipe_deep
            always_ff @(posedge clk) begin
                if (!rst_n) r_vpipe <= '0;
                else        r_vpipe <= {r_vpipe[MUL_LAT-1:0], w_accept};
            end
        end
    endgenerate

    // In-flight count: samples accepted but not yet written into the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Output position within the frame, used to flag the 16th product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_cnt <= '0;
        end else if ((r_state == ST_DONE) || (r_state == ST_IDLE)) begin
            r_out_cnt <= '0;
        end else if (w_pop) begin
            r_out_cnt <= r_out_cnt + 1'b1;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push_vld (w_push),
        .i_push_dat (w_push_dat),
        .i_pop_rdy  (out_ready),
        .o_pop_vld  (w_fifo_vld),
        .o_pop_dat  (w_fifo_dat),
        .o_count    (w_fifo_count)
    );

endmodule

// File: tb/tb_twiddle_mul_sched.sv
// Bench for twiddle_mul_sched with a 2-cycle float multiplier and registered twiddle ROM.
// Reference: frame-level model (accept/pop counts, q*r exponent, product queue).
// Outputs are sampled at negedge+1; inputs change right after the negedge.
module tb_twiddle_mul_sched;

    localparam int MUL_LAT    = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_real;
    logic [31:0] in_im;
    logic [3:0]  tw_addr;
    logic [31:0] tw_real;
    logic [31:0] tw_im;
    logic [31:0] mul_a_real;
    logic [31:0] mul_a_im;
    logic [31:0] mul_b_real;
    logic [31:0] mul_b_im;
    logic [31:0] mul_c_real;
    logic [31:0] mul_c_im;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_real;
    logic [31:0] out_im;
    logic        out_last;

    always #5 clk = ~clk;

    twiddle_mul_sched #(
        .MUL_LAT    (MUL_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_real    (in_real),
        .in_im      (in_im),
        .tw_addr    (tw_addr),
        .tw_real    (tw_real),
        .tw_im      (tw_im),
        .mul_a_real (mul_a_real),
        .mul_a_im   (mul_a_im),
        .mul_b_real (mul_b_real),
        .mul_b_im   (mul_b_im),
        .mul_c_real (mul_c_real),
        .mul_c_im   (mul_c_im),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_real   (out_real),
        .out_im     (out_im),
        .out_last   (out_last)
    );

    // ---------------- float helpers (normal numbers and zero) ----------------
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] ex;
        if (f[30:23] == 8'd0) return 0.0;
        ex = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], ex, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real x);
        logic [63:0] d;
        logic [10:0] ex;
        if (x == 0.0) return 32'd0;
        d  = $realtobits(x);
        ex = d[62:52] - 11'd896;
        return {d[63], ex[7:0], d[51:29]};
    endfunction

    function automatic logic [63:0] cmul(input logic [31:0] ar, input logic [31:0] ai,
                                         input logic [31:0] br, input logic [31:0] bi);
        real xr, xi, yr, yi;
        xr = f2r(ar); xi = f2r(ai); yr = f2r(br); yi = f2r(bi);
        return {r2f(xr * yr - xi * yi), r2f(xr * yi + xi * yr)};
    endfunction

    // Exponent from the sample position: quotient times remainder by 4.
    function automatic int e_of(input int i);
        return (i / 4) * (i % 4);
    endfunction

    // ---------------- external ROM and multiplier models ----------------
    logic [31:0] rom_re [16];
    logic [31:0] rom_im [16];
    logic [63:0] m1, m2;

    always @(posedge clk) begin
        tw_real <= rom_re[tw_addr];
        tw_im   <= rom_im[tw_addr];
        m1      <= cmul(mul_a_real, mul_a_im, mul_b_real, mul_b_im);
        m2      <= m1;
    end
    assign mul_c_real = m2[63:32];
    assign mul_c_im   = m2[31:0];

    // ---------------- scoreboard state ----------------
    int          n_asserts = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          acc_cnt, pop_cnt, last_pop_cyc, first_ov_cyc, acc0_cyc;
    bit          frame_on;
    logic [63:0] first_out;
    logic [63:0] exp_q [$];
    int          tw_seen [16];
    int          exp_tw  [16] = '{0,0,0,0, 0,1,2,3, 0,2,4,6, 0,3,6,9};
    logic [31:0] cur_re, cur_im;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_sample();
        int vr, vi;
        vr = int'($urandom_range(0, 16)) - 8;
        vi = int'($urandom_range(0, 16)) - 8;
        cur_re = r2f(real'(vr));
        cur_im = r2f(real'(vi));
    endtask

    // One clock cycle: drive, check against the frame model, then advance.
    task automatic step(input bit iv, input bit ordy);
        bit run_exp, rdy_exp, done_exp, busy_exp, acc, pop;
        in_valid  = iv;
        in_real   = cur_re;
        in_im     = cur_im;
        out_ready = ordy;
        #1;
        run_exp  = frame_on && (acc_cnt < 16);
        rdy_exp  = run_exp && ((acc_cnt - pop_cnt) < FIFO_DEPTH);
        done_exp = frame_on && (pop_cnt == 16) && ((cyc - last_pop_cyc) == 2);
        busy_exp = frame_on && !((pop_cnt == 16) && ((cyc - last_pop_cyc) >= 2));
        chk("in_ready", 64'(in_ready), 64'(rdy_exp));
        chk("busy", 64'(busy), 64'(busy_exp));
        chk("done", 64'(done), 64'(done_exp));
        chk("tw_addr", 64'(tw_addr), run_exp ? 64'(e_of(acc_cnt)) : 64'd0);
        chk("no_overflow", 64'((acc_cnt - pop_cnt) <= FIFO_DEPTH), 64'd1);
        if (out_valid) begin
            if (first_ov_cyc < 0) begin
                first_ov_cyc = cyc;
                first_out    = {out_real, out_im};
            end
            chk("out_last", 64'(out_last), 64'(pop_cnt == 15));
            if (exp_q.size() == 0) chk("out_valid_spurious", 64'(out_valid), 64'd0);
            else                   chk("out_dat", {out_real, out_im}, exp_q[0]);
        end else begin
            chk("out_last_idle", 64'(out_last), 64'd0);
        end
        acc = iv && in_ready;
        pop = out_valid && ordy && (exp_q.size() > 0);
        if (acc && acc_cnt < 16) begin
            tw_seen[acc_cnt] = int'(tw_addr);
            if (acc_cnt == 0) acc0_cyc = cyc;
            exp_q.push_back(cmul(cur_re, cur_im, rom_re[e_of(acc_cnt)], rom_im[e_of(acc_cnt)]));
            acc_cnt++;
            new_sample();
        end
        if (pop) begin
            void'(exp_q.pop_front());
            pop_cnt++;
            if (pop_cnt == 16) last_pop_cyc = cyc;
        end
        if (done_exp) frame_on = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic start_frame();
        start = 1'b1;
        step(1'b0, 1'b1);
        start        = 1'b0;
        frame_on     = 1'b1;
        acc_cnt      = 0;
        pop_cnt      = 0;
        last_pop_cyc = -100;
        first_ov_cyc = -1;
        acc0_cyc     = -1;
        exp_q.delete();
    endtask

    task automatic run_frame(input int pv, input int pr, input bit poke);
        int g;
        g = 0;
        while (frame_on && g < 3000) begin
            start = poke && ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 99) < pv, $urandom_range(0, 99) < pr);
            g++;
        end
        start = 1'b0;
        chk("frame_timeout", 64'(frame_on), 64'd0);
    endtask

    task automatic chk_tw_table();
        for (int i = 0; i < 16; i++) chk("tw_seq", 64'(tw_seen[i]), 64'(exp_tw[i]));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_tw_addr", 64'(tw_addr), 64'd0);
        chk("rst_mul_a", {mul_a_real, mul_a_im}, 64'd0);
    endtask

    initial begin
        int g;
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_real   = '0;
        in_im     = '0;
        frame_on  = 1'b0;
        acc_cnt   = 0;
        pop_cnt   = 0;
        last_pop_cyc = -100;
        first_ov_cyc = -1;
        acc0_cyc  = -1;
        for (int i = 0; i < 16; i++) begin
            rom_re[i]  = r2f(real'(i + 1));
            rom_im[i]  = r2f(real'(-i));
            tw_seen[i] = -1;
        end
        new_sample();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Frame 1: always-valid input, always-ready output, exponent sequence
        start_frame();
        run_frame(100, 100, 1'b0);
        chk_tw_table();

        // Frame 2: identity twiddle on idx0 and end-to-end latency
        start_frame();
        cur_re = 32'h4000_0000;
        cur_im = 32'h3F80_0000;
        run_frame(100, 100, 1'b0);
        chk("identity_out", first_out, 64'h4000_0000_3F80_0000);
        chk("latency", 64'(first_ov_cyc - acc0_cyc), 64'd4);

        // Frame 3: output stalled, credits must cap accepts at FIFO_DEPTH
        start_frame();
        repeat (12) step(1'b1, 1'b0);
        chk("bp_accepts", 64'(acc_cnt), 64'(FIFO_DEPTH));
        chk("bp_held", 64'(exp_q.size()), 64'(FIFO_DEPTH));
        run_frame(100, 100, 1'b0);

        // Frames 4-6: random valid/ready with start pokes while busy
        repeat (3) begin
            start_frame();
            run_frame(50, 50, 1'b1);
        end

        // Frame 7: reset after 7 accepts, then a clean frame
        start_frame();
        g = 0;
        while (acc_cnt < 7 && g < 500) begin
            step(1'b1, $urandom_range(0, 1) == 1);
            g++;
        end
        chk("pre_reset_accepts", 64'(acc_cnt), 64'd7);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        #1;
        chk_reset_outputs();
        rst_n    = 1'b1;
        frame_on = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) tw_seen[i] = -1;
        @(negedge clk);
        cyc++;
        start_frame();
        run_frame(100, 100, 1'b0);
        chk_tw_table();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
